// File: rtl/sd_cmd_master.sv
// sd_cmd_master: issues one SD command through the controller's byte-wide
// register port, polls the command ISR, fetches response word 0, clears the
// ISR and reports the result to the requester.
`timescale 1ns/1ps
module sd_cmd_master #(
    parameter int         CMD_W     = 14,
    parameter int         ISR_W     = 5,
    parameter int         HOLDOFF   = 16,
    parameter int         POLL_MAX  = 65535,
    parameter logic [6:0] A_ARG     = 7'h00,
    parameter logic [6:0] A_CMD     = 7'h04,
    parameter logic [6:0] A_RESP0   = 7'h08,
    parameter logic [6:0] A_CMD_ISR = 7'h34
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [CMD_W-1:0]   req_cmd,
    input  logic [31:0]        req_arg,
    output logic               done_valid,
    output logic [ISR_W:0]     done_status,
    output logic [31:0]        done_resp,
    output logic               bus_we,
    output logic [6:0]         bus_addr,
    output logic [7:0]         bus_wdata,
    input  logic [7:0]         bus_rdata
);

    // One counter serves the byte sequencing, the holdoff and the poll budget.
    localparam int CNT_MAX = (POLL_MAX > HOLDOFF) ? ((POLL_MAX > 4) ? POLL_MAX : 4)
                                                  : ((HOLDOFF > 4) ? HOLDOFF : 4);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_THREE = CW'(3);
    localparam logic [CW-1:0] HOLD_LAST = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [CW-1:0] POLL_LAST = CW'((POLL_MAX > 0) ? POLL_MAX - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_CMD, S_WR_ARG, S_HOLD, S_POLL, S_RD_RESP, S_CLR, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [31:0]        arg_q, arg_d;
    logic [ISR_W-1:0]   isr_q, isr_d;
    logic               tmo_q, tmo_d;
    logic [31:0]        resp_q, resp_d;
    logic               req_ready_q, req_ready_d;
    logic               done_valid_q, done_valid_d;
    logic [ISR_W:0]     done_status_q, done_status_d;
    logic [31:0]        done_resp_q, done_resp_d;
    logic               bus_we_q, bus_we_d;
    logic [6:0]         bus_addr_q, bus_addr_d;
    logic [7:0]         bus_wdata_q, bus_wdata_d;
    logic [15:0]        cmd_ext_s;
    logic [1:0]         arg_sel_s;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Next-state, counters, captured ISR/response and requester-side outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_d         = cmd_q;
        arg_d         = arg_q;
        isr_d         = isr_q;
        tmo_d         = tmo_q;
        resp_d        = resp_q;
        req_ready_d   = 1'b0;
        done_valid_d  = 1'b0;
        done_status_d = done_status_q;
        done_resp_d   = done_resp_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    cmd_d   = req_cmd;
                    arg_d   = req_arg;
                    isr_d   = '0;
                    tmo_d   = 1'b0;
                    resp_d  = 32'h0000_0000;
                    cnt_d   = '0;
                    state_d = S_WR_CMD;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_WR_CMD: begin
                if (cnt_q == CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = S_WR_ARG;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WR_ARG: begin
                if (cnt_q == CNT_THREE) begin
                    cnt_d   = '0;
                    state_d = (HOLDOFF == 0) ? S_POLL : S_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_POLL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_POLL: begin
                if (bus_rdata[1:0] != 2'b00) begin
                    isr_d   = bus_rdata[ISR_W-1:0];
                    cnt_d   = '0;
                    state_d = S_RD_RESP;
                end else if (cnt_q == POLL_LAST) begin
                    tmo_d   = 1'b1;
                    isr_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CLR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RD_RESP: begin
                case (cnt_q[1:0])
                    2'd0:    resp_d[7:0]   = bus_rdata;
                    2'd1:    resp_d[15:8]  = bus_rdata;
                    2'd2:    resp_d[23:16] = bus_rdata;
                    2'd3:    resp_d[31:24] = bus_rdata;
                    default: resp_d        = resp_q;
                endcase
                if (cnt_q == CNT_THREE) begin
                    cnt_d   = '0;
                    state_d = S_CLR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_CLR: begin
                state_d       = S_DONE;
                done_valid_d  = 1'b1;
                done_status_d = {tmo_q, isr_q};
                done_resp_d   = resp_q;
            end
            S_DONE: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // Bus drive for the cycle about to start, decoded from the next state.
    always_comb begin
        bus_we_d    = 1'b0;
        bus_addr_d  = 7'h00;
        bus_wdata_d = 8'h00;
        cmd_ext_s   = 16'(cmd_d);
        arg_sel_s   = 2'd0;
        case (state_d)
            S_WR_CMD: begin
                bus_we_d = 1'b1;
                if (cnt_d == '0) begin
                    bus_addr_d  = A_CMD + 7'd1;
                    bus_wdata_d = cmd_ext_s[15:8];
                end else begin
                    bus_addr_d  = A_CMD;
                    bus_wdata_d = cmd_ext_s[7:0];
                end
            end
            S_WR_ARG: begin
                // Byte 0 goes last: writing it fires cmd_start.
                arg_sel_s   = 2'd3 - cnt_d[1:0];
                bus_we_d    = 1'b1;
                bus_addr_d  = A_ARG + {5'd0, arg_sel_s};
                bus_wdata_d = byte_of(arg_d, arg_sel_s);
            end
            S_POLL: begin
                bus_addr_d = A_CMD_ISR;
            end
            S_RD_RESP: begin
                bus_addr_d = A_RESP0 + {5'd0, cnt_d[1:0]};
            end
            S_CLR: begin
                bus_we_d   = 1'b1;
                bus_addr_d = A_CMD_ISR;
            end
            default: begin
                bus_we_d = 1'b0;
            end
        endcase
    end

    // State, working registers and registered outputs; reset aborts at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cmd_q         <= '0;
            arg_q         <= 32'h0000_0000;
            isr_q         <= '0;
            tmo_q         <= 1'b0;
            resp_q        <= 32'h0000_0000;
            req_ready_q   <= 1'b1;
            done_valid_q  <= 1'b0;
            done_status_q <= '0;
            done_resp_q   <= 32'h0000_0000;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 7'h00;
            bus_wdata_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_q         <= cmd_d;
            arg_q         <= arg_d;
            isr_q         <= isr_d;
            tmo_q         <= tmo_d;
            resp_q        <= resp_d;
            req_ready_q   <= req_ready_d;
            done_valid_q  <= done_valid_d;
            done_status_q <= done_status_d;
            done_resp_q   <= done_resp_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign done_valid  = done_valid_q;
    assign done_status = done_status_q;
    assign done_resp   = done_resp_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_sd_cmd_master.sv
// tb_sd_cmd_master: drives command requests against a behavioural model of
// the controller register port and checks bus traffic, latency and results.
`timescale 1ns/1ps
module tb_sd_cmd_master;

    localparam int HOLD = 2;
    localparam int PMAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [13:0] req_cmd;
    logic [31:0] req_arg;
    logic        done_valid;
    logic [5:0]  done_status;
    logic [31:0] done_resp;
    logic        bus_we;
    logic [6:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Controller model state, configured per transaction
    int          cur_hit   = 0;
    logic [4:0]  cur_isr   = 5'h00;
    logic [2:0]  cur_top   = 3'b000;
    logic [7:0]  cur_pre   = 8'h00;
    logic [31:0] cur_resp  = 32'h0;
    int          poll_base = 0;

    // Monitor state
    logic [15:0] log_q[$];
    int          total_polls = 0;
    int          wd_viol = 0;

    sd_cmd_master #(.HOLDOFF(HOLD), .POLL_MAX(PMAX)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_arg(req_arg),
        .done_valid(done_valid), .done_status(done_status), .done_resp(done_resp),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Combinational read port of the modelled controller
    always_comb begin
        bus_rdata = 8'h5A;
        case (bus_addr)
            7'h34: begin
                if (cur_hit != 0 && (total_polls - poll_base + 1) >= cur_hit)
                    bus_rdata = {cur_top, cur_isr};
                else
                    bus_rdata = cur_pre;
            end
            7'h08: bus_rdata = cur_resp[7:0];
            7'h09: bus_rdata = cur_resp[15:8];
            7'h0A: bus_rdata = cur_resp[23:16];
            7'h0B: bus_rdata = cur_resp[31:24];
            default: bus_rdata = 8'h5A;
        endcase
    end

    // Record every write and every read of ISR/response registers
    always @(posedge clk) begin
        if (!rst) begin
            if (bus_we)
                log_q.push_back({1'b1, bus_addr, bus_wdata});
            else if (bus_addr == 7'h34 || (bus_addr >= 7'h08 && bus_addr <= 7'h0B))
                log_q.push_back({1'b0, bus_addr, 8'h00});
            if (!bus_we && bus_addr == 7'h34)
                total_polls <= total_polls + 1;
            if (!bus_we && bus_wdata != 8'h00)
                wd_viol <= wd_viol + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full request; called right after a falling edge.
    task automatic run_txn(input logic [13:0] cmd, input logic [31:0] arg, input int hit,
                           input logic [4:0] isr, input logic [31:0] resp,
                           input bit keep, input bit b2b);
        logic [15:0] exp_q[$];
        bit          tmo;
        int          polls, exp_lat, waits, k, rviol, lbase, nlog;
        logic [5:0]  exp_status;
        logic [31:0] exp_resp;

        tmo        = (hit == 0 || hit > PMAX);
        polls      = tmo ? PMAX : hit;
        exp_lat    = 6 + HOLD + polls + (tmo ? 0 : 4) + 2;
        exp_status = tmo ? 6'h20 : {1'b0, isr};
        exp_resp   = tmo ? 32'h0 : resp;

        exp_q.push_back({1'b1, 7'h05, 2'b00, cmd[13:8]});
        exp_q.push_back({1'b1, 7'h04, cmd[7:0]});
        for (int b = 3; b >= 0; b--) exp_q.push_back({1'b1, 7'(b), arg[8*b +: 8]});
        for (int p = 0; p < polls; p++) exp_q.push_back({1'b0, 7'h34, 8'h00});
        if (!tmo) for (int r = 0; r < 4; r++) exp_q.push_back({1'b0, 7'(8 + r), 8'h00});
        exp_q.push_back({1'b1, 7'h34, 8'h00});

        cur_hit   = hit;
        cur_isr   = isr;
        cur_top   = 3'($urandom);
        cur_pre   = 8'($urandom) & 8'hFC;
        cur_resp  = resp;
        poll_base = total_polls;
        req_cmd   = cmd;
        req_arg   = arg;
        req_valid = 1'b1;

        waits = 0;
        while (!req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check("accept_ready", {31'd0, req_ready}, 32'd1);
        if (b2b) check("b2b_accept_wait", waits, 32'd0);
        lbase = log_q.size();
        @(posedge clk);
        @(negedge clk);
        k = 1;
        rviol = 0;
        if (!keep) req_valid = 1'b0;
        while (!done_valid && k < 200) begin
            if (req_ready) rviol++;
            @(negedge clk);
            k++;
        end
        check("latency", k, exp_lat);
        check("done_status", {26'd0, done_status}, {26'd0, exp_status});
        check("done_resp", done_resp, exp_resp);
        check("ready_in_done", {31'd0, req_ready}, 32'd0);
        check("ready_busy_viol", rviol, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done_valid}, 32'd0);
        check("ready_after_done", {31'd0, req_ready}, 32'd1);
        check("resp_held", done_resp, exp_resp);
        nlog = log_q.size() - lbase;
        check("bus_evt_count", nlog, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < nlog; i++)
            check("bus_evt", {16'(i), log_q[lbase + i]}, {16'(i), exp_q[i]});
    endtask

    // Never hang
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] risr;
        int         dv_cnt;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_cmd   = 14'h0;
        req_arg   = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_done_valid", {31'd0, done_valid}, 32'd0);
        check("rst_done_status", {26'd0, done_status}, 32'd0);
        check("rst_done_resp", done_resp, 32'd0);
        check("rst_bus_we", {31'd0, bus_we}, 32'd0);
        check("rst_bus_addr", {25'd0, bus_addr}, 32'd0);
        check("rst_bus_wdata", {24'd0, bus_wdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Card-init style command, ISR complete on third poll
        run_txn(14'h0109, 32'h0000_01AA, 3, 5'h01, 32'h0000_01AA, 1'b0, 1'b0);
        // Error on first poll
        run_txn(14'(($urandom)), $urandom, 1, 5'h02, $urandom, 1'b0, 1'b0);
        // Timeout: ISR never set
        run_txn(14'(($urandom)), $urandom, 0, 5'h01, $urandom, 1'b0, 1'b0);
        // req_valid held high: back-to-back acceptance
        run_txn(14'(($urandom)), $urandom, 2, 5'h03, $urandom, 1'b1, 1'b0);
        run_txn(14'(($urandom)), $urandom, 1, 5'h11, $urandom, 1'b0, 1'b1);

        // Reset during WR_ARG byte 2
        req_cmd   = 14'h2ABC;
        req_arg   = 32'h1234_5678;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_addr", {24'd0, bus_we, bus_addr}, {24'd0, 1'b1, 7'h02});
        rst = 1'b1;
        #1;
        check("rst_mid_we", {31'd0, bus_we}, 32'd0);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        dv_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_valid) dv_cnt++;
        end
        rst = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done_valid) dv_cnt++;
        end
        check("no_done_after_abort", dv_cnt, 32'd0);
        run_txn(14'h0109, 32'hCAFE_F00D, 4, 5'h05, 32'h8765_4321, 1'b0, 1'b0);

        // Randomized requests
        for (int t = 0; t < 10; t++) begin
            risr = 5'($urandom);
            if (risr[1:0] == 2'b00) risr[0] = 1'b1;
            run_txn(14'($urandom), $urandom, int'($urandom_range(0, 10)), risr, $urandom,
                    1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        check("wdata_zero_when_idle", wd_viol, 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
